// File: rtl/wb_regbank.sv
// Wishbone-style register bank: read-write config registers plus top-indexed read-only status words.
// Optional WB_REGBANK_ERR_EN adds ERR_I for out-of-range accesses and writes to read-only registers.
module wb_regbank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RO   = 2,
  parameter int ADDR_W   = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     CYC_O,
  input  logic                                     STB_O,
  input  logic                                     WE_O,
  input  logic [ADDR_W-1:0]                        ADR_O,
  input  logic [DATA_W-1:0]                        DAT_O,
  output logic [DATA_W-1:0]                        DAT_I,
  output logic                                     ACK_I,
  input  logic [((NUM_RO > 0) ? NUM_RO*DATA_W : 1)-1:0] status_in,
  output logic [(NUM_REGS-NUM_RO)*DATA_W-1:0]      cfg_out,
  output logic [NUM_REGS-1:0]                      wr_pulse
`ifdef WB_REGBANK_ERR_EN
  ,
  output logic                                     ERR_I
`endif
);

  localparam int NUM_RW = NUM_REGS - NUM_RO;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_RW];
  logic [DATA_W-1:0]   regs_d [NUM_RW];
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                ack_q, ack_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]   reg_view [NUM_REGS];
  logic [DATA_W-1:0]   rd_val;
  logic                accept;
`ifdef WB_REGBANK_ERR_EN
  logic                err_q, err_d;
  logic                bad;
`endif

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    assign reg_view[i]                 = regs_q[i];
    assign cfg_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  if (NUM_RO > 0) begin : g_ro
    for (genvar k = 0; k < NUM_RO; k++) begin : g_word
      assign reg_view[NUM_RW+k] = status_in[k*DATA_W +: DATA_W];
    end
  end else begin : g_no_ro
    logic unused_status;
    assign unused_status = ^status_in;
  end

  always_comb begin
    accept     = (state_q == IDLE) && CYC_O && STB_O;
    state_d    = accept ? RESP : IDLE;
    rd_val     = '0;
    wr_pulse_d = '0;
    // Full-width compare so high address bits never alias onto low registers
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADR_O == ADDR_W'(i)) rd_val = reg_view[i];
    end
    for (int i = 0; i < NUM_RW; i++) begin
      regs_d[i] = regs_q[i];
      if (accept && WE_O && (ADR_O == ADDR_W'(i))) begin
        regs_d[i]     = DAT_O;
        wr_pulse_d[i] = 1'b1;
      end
    end
    dat_d = (accept && !WE_O) ? rd_val : '0;
`ifdef WB_REGBANK_ERR_EN
    bad   = (ADR_O >= ADDR_W'(NUM_REGS)) || (WE_O && (ADR_O >= ADDR_W'(NUM_RW)));
    ack_d = accept && !bad;
    err_d = accept && bad;
`else
    ack_d = accept;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
`ifdef WB_REGBANK_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= regs_d[i];
`ifdef WB_REGBANK_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  // A master dropping CYC_O in the response cycle aborts the acknowledge only
  assign ACK_I    = ack_q & CYC_O;
  assign DAT_I    = dat_q;
  assign wr_pulse = wr_pulse_q;
`ifdef WB_REGBANK_ERR_EN
  assign ERR_I    = err_q & CYC_O;
`endif

endmodule

// File: tb/tb_wb_regbank.sv
// Randomized and directed bench for wb_regbank against an array-based register model.
module tb_wb_regbank;
  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int NRO = 2;
  localparam int AW  = 16;
  localparam int NRW = NR - NRO;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              CYC_O = 1'b0;
  logic              STB_O = 1'b0;
  logic              WE_O = 1'b0;
  logic [AW-1:0]     ADR_O = '0;
  logic [DW-1:0]     DAT_O = '0;
  logic [DW-1:0]     DAT_I;
  logic              ACK_I;
  logic [NRO*DW-1:0] status_in = '0;
  logic [NRW*DW-1:0] cfg_out;
  logic [NR-1:0]     wr_pulse;
`ifdef WB_REGBANK_ERR_EN
  logic              ERR_I;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [DW-1:0] mdl_rw [NRW];

  wb_regbank #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RO(NRO), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I),
    .status_in(status_in), .cfg_out(cfg_out), .wr_pulse(wr_pulse)
`ifdef WB_REGBANK_ERR_EN
    , .ERR_I(ERR_I)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NRW*DW-1:0] mdl_cfg();
    logic [NRW*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NRW; i++) v[i*DW +: DW] = mdl_rw[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] mdl_read(input int a);
    if (a < NRW) return mdl_rw[a];
    if (a < NR) return status_in[(a-NRW)*DW +: DW];
    return '0;
  endfunction

  // One complete access from IDLE; checks everything visible in the response cycle
  task automatic bus_xfer(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [NRO*DW-1:0] st, input string tag);
    logic [DW-1:0] exp_dat;
    logic [NR-1:0] exp_pulse;
    bit            bad;
    int            a;
    a = int'(addr);
    @(negedge clk);
    status_in = st;
    CYC_O = 1'b1; STB_O = 1'b1; WE_O = we; ADR_O = addr; DAT_O = data;
    exp_dat   = we ? '0 : mdl_read(a);
    exp_pulse = '0;
    bad       = (a >= NR) || (we && a >= NRW);
    if (we && a < NRW) begin
      mdl_rw[a]    = data;
      exp_pulse[a] = 1'b1;
    end
    chk({tag, ":ack_before_edge"}, ACK_I, 0);
    @(posedge clk);
    @(negedge clk);
`ifdef WB_REGBANK_ERR_EN
    chk({tag, ":ack"}, ACK_I, !bad);
    chk({tag, ":err"}, ERR_I, bad);
`else
    chk({tag, ":ack"}, ACK_I, 1);
    if (bad) chk({tag, ":ack_bad_addr"}, ACK_I, 1);
`endif
    chk({tag, ":dat"}, DAT_I, exp_dat);
    chk({tag, ":pulse"}, wr_pulse, exp_pulse);
    chk({tag, ":cfg"}, cfg_out, mdl_cfg());
    CYC_O = 1'b0; STB_O = 1'b0; WE_O = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [AW-1:0] addr;
    logic          prev_ack;
    int            n_ack;
    for (int i = 0; i < NRW; i++) mdl_rw[i] = '0;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:ack", ACK_I, 0);
    chk("rst:dat", DAT_I, 0);
    chk("rst:pulse", wr_pulse, 0);
    chk("rst:cfg", cfg_out, 0);
`ifdef WB_REGBANK_ERR_EN
    chk("rst:err", ERR_I, 0);
`endif
    reset_n = 1'b1;

    bus_xfer(1'b1, 16'd0, 16'h1234, 32'h0, "wr0");
    bus_xfer(1'b0, 16'd0, 16'h0000, 32'h0, "rd0");
    bus_xfer(1'b0, 16'd7, 16'h0000, {16'hBEEF, 16'h0123}, "rd7");
    bus_xfer(1'b1, 16'd7, 16'h5555, {16'hBEEF, 16'h0123}, "wr7");
    bus_xfer(1'b0, 16'd7, 16'h0000, {16'hBEEF, 16'h0123}, "rerd7");
    bus_xfer(1'b0, 16'd6, 16'h0000, {16'hBEEF, 16'h0123}, "rd6");
    bus_xfer(1'b0, 16'd9, 16'h0000, {16'hBEEF, 16'h0123}, "rd9");
    bus_xfer(1'b1, 16'h0101, 16'h7777, {16'hBEEF, 16'h0123}, "wr_alias");
    bus_xfer(1'b0, 16'd1, 16'h0000, {16'hBEEF, 16'h0123}, "rd1_noalias");

    // Strobe held continuously: acknowledges must alternate
    bus_xfer(1'b1, 16'd1, 16'h4321, status_in, "wr1");
    @(negedge clk);
    CYC_O = 1'b1; STB_O = 1'b1; WE_O = 1'b0; ADR_O = 16'd1;
    prev_ack = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      chk("hold:ack_pattern", ACK_I, (c % 2) == 1);
      chk("hold:dat", DAT_I, (c % 2 == 1) ? 16'h4321 : 16'h0);
      chk("hold:no_consec", ACK_I && prev_ack, 0);
      if (ACK_I) n_ack++;
      prev_ack = ACK_I;
      @(negedge clk);
    end
    chk("hold:ack_count", n_ack, 4);
    CYC_O = 1'b0; STB_O = 1'b0;
    @(posedge clk);

    // Abort in response cycle: write stays committed
    @(negedge clk);
    CYC_O = 1'b1; STB_O = 1'b1; WE_O = 1'b1; ADR_O = 16'd2; DAT_O = 16'hAAAA;
    mdl_rw[2] = 16'hAAAA;
    @(posedge clk);
    #1 CYC_O = 1'b0; STB_O = 1'b0;
    @(negedge clk);
    chk("abort:ack", ACK_I, 0);
    chk("abort:pulse", wr_pulse, 8'h04);
    chk("abort:cfg", cfg_out, mdl_cfg());
    WE_O = 1'b0;
    @(posedge clk);

    // Reset during response cycle clears the committed write
    @(negedge clk);
    CYC_O = 1'b1; STB_O = 1'b1; WE_O = 1'b1; ADR_O = 16'd3; DAT_O = 16'hFFFF;
    mdl_rw[3] = 16'hFFFF;
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rstresp:cfg_committed", cfg_out, mdl_cfg());
    STB_O = 1'b0; WE_O = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NRW; i++) mdl_rw[i] = '0;
    chk("rstresp:ack", ACK_I, 0);
    chk("rstresp:dat", DAT_I, 0);
    chk("rstresp:pulse", wr_pulse, 0);
    chk("rstresp:cfg", cfg_out, mdl_cfg());
    CYC_O = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = AW'($urandom_range(0, 65535));
        1:       addr = AW'(16'h0100 + 16'($urandom_range(0, 7)));
        default: addr = AW'($urandom_range(0, 11));
      endcase
      bus_xfer(1'($urandom_range(0, 1)), addr, DW'($urandom_range(0, 65535)),
               NRO*DW'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_regbank.md
WB_REGBANK -- requirements
Module: wb_regbank

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 16: register and bus data width.
- NUM_REGS, 8: total register count, at least 2.
- NUM_RO, 2: number of top-indexed read-only status registers, in the range 0 to NUM_REGS-1.
- ADDR_W, 16: bus address width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low. Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset_n, in, 1: synchronous active-low reset.
- CYC_O, in, 1: bus cycle valid.
- STB_O, in, 1: strobe.
- WE_O, in, 1: 1 = write, 0 = read.
- ADR_O, in, ADDR_W: word address.
- DAT_O, in, DATA_W: write data.
- DAT_I, out, DATA_W: read data.
- ACK_I, out, 1: access acknowledge.
- status_in, in, NUM_RO*DATA_W: hardware status words; word k maps to register NUM_REGS-NUM_RO+k.
- cfg_out, out, (NUM_REGS-NUM_RO)*DATA_W: live contents of the read-write registers, word i = register i.
- wr_pulse, out, NUM_REGS: one-cycle write strobe per register.
- ERR_I, out, 1: error acknowledge; present only under REQ-019.

Function
REQ-003 Registers 0..NUM_REGS-NUM_RO-1 SHALL be read-write; registers NUM_REGS-NUM_RO..NUM_REGS-1 SHALL be read-only.
REQ-004 The handshake SHALL be a two-state FSM, IDLE and RESP:
- IDLE goes to RESP when CYC_O=1 and STB_O=1.
- RESP always returns to IDLE on the next cycle.
REQ-005 The access SHALL be performed on the IDLE->RESP clock edge. Address, data and status_in are sampled at that edge.
REQ-006 ACK_I SHALL be registered and high for exactly the single RESP cycle. Latency is 1 cycle after strobe; throughput is at most one access per 2 cycles.
REQ-007 STB_O asserted during RESP SHALL be ignored and SHALL NOT queue an access. The master re-presents it, and it is accepted from IDLE.
REQ-008 An in-range write to a read-write register SHALL load DAT_O at the IDLE->RESP edge. cfg_out reflects the new value from the RESP cycle onward.
REQ-009 wr_pulse[i] SHALL be high for the RESP cycle only, and only for a successful write to register i.
REQ-010 A write to a read-only register SHALL be discarded with no state change and no wr_pulse.
REQ-011 A read SHALL load DAT_I with the addressed register at the IDLE->RESP edge:
- a read-only register returns its status_in word as sampled at that edge;
- out-of-range addresses (ADR_O >= NUM_REGS) return 0.
REQ-012 DAT_I SHALL be 0 in every cycle except a read's RESP cycle.
REQ-013 An out-of-range write SHALL be discarded and still be acknowledged, except under REQ-019.
REQ-014 If CYC_O is 0 during RESP, ACK_I SHALL be suppressed to 0 (abort). A write already committed at the IDLE->RESP edge remains committed.
REQ-015 Address decode SHALL use the full ADR_O width with no aliasing.

Reset
REQ-016 When reset_n=0 at a clock edge, the following SHALL hold on the next cycle:
- FSM state is IDLE;
- all read-write registers are 0;
- ACK_I, DAT_I, wr_pulse and ERR_I are 0.
REQ-017 Reset asserted during RESP SHALL cancel the pending ACK_I and DAT_I, and SHALL clear any write committed in that access.
REQ-018 With NUM_RO=0 the block SHALL have no read-only registers. status_in is then unused, held at width 1, and ignored.

Configuration
REQ-019 With macro WB_REGBANK_ERR_EN defined, the ERR_I port SHALL exist. Out-of-range accesses and writes to read-only registers then assert ERR_I instead of ACK_I for the RESP cycle, with the same timing and abort rules as ACK_I.
REQ-020 Without WB_REGBANK_ERR_EN, ERR_I SHALL be absent, and every accepted access is acknowledged with ACK_I.

Verification
REQ-021 Write 0x1234 to address 0, then read address 0:
- write: ACK_I 1 cycle after STB_O, wr_pulse[0] for one cycle, cfg_out word 0 = 0x1234;
- read: DAT_I=0x1234 with ACK_I.
REQ-022 With default parameters, status_in word 1 = 0xBEEF; read address 7 -> DAT_I=0xBEEF. Write 0x5555 to address 7 -> no wr_pulse, and a re-read still returns 0xBEEF.
REQ-023 Read address 9 -> DAT_I=0 with ACK_I; with WB_REGBANK_ERR_EN -> ERR_I=1 and ACK_I=0.
REQ-024 Hold CYC_O=STB_O=1 continuously over 4 reads -> ACK_I pattern 0,1,0,1; no ACK_I in consecutive cycles.
REQ-025 Write 0xAAAA to address 2, then drop CYC_O in RESP -> ACK_I=0, and register 2 = 0xAAAA.
REQ-026 Write 0xFFFF to address 3, then assert reset_n=0 in RESP -> next cycle ACK_I=0 and register 3 = 0.
